// File: rtl/jtframe_mixer_pkg.sv
// Shared definitions for the time-multiplexed audio mixers.
package jtframe_mixer_pkg;

  // Mixer sequencer states. The encoding is fixed so other mixers can share it.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StOut  = 2'd2
  } mix_state_e;

  // Gains are 4.4 fixed point: four fractional bits are dropped after the sum.
  localparam int unsigned GAIN_FRAC = 4;

  // Accumulator width holding CH products of (wi x 8) bits without overflow.
  function automatic int unsigned acc_width(input int unsigned wi, input int unsigned ch);
    return wi + 8 + $clog2(ch);
  endfunction

endpackage

// File: rtl/jtframe_sat.sv
// Signed saturation from WIN bits down to WOUT bits with a clip indicator.
module jtframe_sat #(
  parameter int unsigned WIN  = 24,
  parameter int unsigned WOUT = 16
) (
  input  logic [WIN-1:0]  i_val,
  output logic [WOUT-1:0] o_val,
  output logic            o_clip
);

  if (WIN > WOUT) begin : g_sat
    // In range only when all bits above the output sign bit copy the sign.
    logic [WIN-WOUT:0] w_top;
    logic              w_in_range;

    assign w_top      = i_val[WIN-1:WOUT-1];
    assign w_in_range = (&w_top) || !(|w_top);
    assign o_clip     = !w_in_range;
    assign o_val      = w_in_range   ? i_val[WOUT-1:0]                 :
                        i_val[WIN-1] ? {1'b1, {(WOUT-1){1'b0}}}        :
                                       {1'b0, {(WOUT-1){1'b1}}};
  end else begin : g_pass
    // Output is at least as wide as the input: sign-extend, never clips.
    logic signed [WIN-1:0] w_sval;

    assign w_sval = i_val;
    assign o_clip = 1'b0;
    assign o_val  = WOUT'(w_sval);
  end

endmodule

// File: rtl/jtframe_mixer_seq.sv
// Time-multiplexed CH-channel audio mixer: one shared multiplier, one channel per cycle,
// saturated registered output with a sample strobe and a retriggerable peak-hold flag.
module jtframe_mixer_seq
  import jtframe_mixer_pkg::*;
#(
  parameter int unsigned CH        = 4,
  parameter int unsigned WI        = 16,
  parameter int unsigned WO        = 16,
  parameter int unsigned PEAK_HOLD = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [CH*WI-1:0] ch,
  input  logic [CH*8-1:0]  gain,
  input  logic [CH-1:0]    mute,
  output logic [WO-1:0]    mixed,
  output logic             sample,
  output logic             peak,
  output logic             busy
);

  localparam int unsigned PRW = WI + 8;
  localparam int unsigned AW  = acc_width(WI, CH);
  localparam int unsigned IW  = $clog2(CH);
  localparam int unsigned LSH = (WO > WI) ? WO - WI : 0;
  localparam int unsigned RSH = (WI > WO) ? WI - WO : 0;
  localparam int unsigned SW  = AW + LSH;
  localparam int unsigned PW  = $clog2(PEAK_HOLD + 1);

  mix_state_e r_state, w_state_next;

  logic [CH*WI-1:0]      r_ch;
  logic [CH*8-1:0]       r_gain;
  logic [CH-1:0]         r_mute;
  logic [IW-1:0]         r_idx;
  logic signed [AW-1:0]  r_acc;
  logic [WO-1:0]         r_mixed;
  logic                  r_sample;
  logic [PW-1:0]         r_peak_cnt;

  logic                  w_load;
  logic                  w_step;
  logic                  w_out;
  logic signed [WI-1:0]  w_ch_sel;
  logic signed [7:0]     w_gain_sel;
  logic signed [PRW-1:0] w_prod;
  logic signed [AW-1:0]  w_shr;
  logic signed [SW-1:0]  w_ext;
  logic signed [SW-1:0]  w_aligned;
  logic [WO-1:0]         w_sat;
  logic                  w_clip;

  // State register; reset abandons any mix in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state logic and the per-state datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_out        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cen) begin
          w_load       = 1'b1;
          w_state_next = StMac;
        end
      end
      StMac: begin
        w_step = 1'b1;
        if (r_idx == IW'(CH - 1)) w_state_next = StOut;
      end
      StOut: begin
        w_out        = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Shared multiplier works on the shadow copies, so live inputs may change mid-mix.
  assign w_ch_sel   = r_ch[r_idx*WI +: WI];
  assign w_gain_sel = r_gain[r_idx*8 +: 8];
  assign w_prod     = r_mute[r_idx] ? '0 : PRW'(w_ch_sel) * PRW'(w_gain_sel);

  // Drop the gain fraction, then align the input scale to the output scale.
  assign w_shr     = r_acc >>> GAIN_FRAC;
  assign w_ext     = SW'(w_shr);
  assign w_aligned = (w_ext <<< LSH) >>> RSH;

  jtframe_sat #(
    .WIN  (SW),
    .WOUT (WO)
  ) u_sat (
    .i_val  (w_aligned),
    .o_val  (w_sat),
    .o_clip (w_clip)
  );

  // Shadow latch, multiply-accumulate, output register and peak-hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch       <= '0;
      r_gain     <= '0;
      r_mute     <= '0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_mixed    <= '0;
      r_sample   <= 1'b0;
      r_peak_cnt <= '0;
    end else begin
      r_sample <= 1'b0;
      if (w_load) begin
        r_ch   <= ch;
        r_gain <= gain;
        r_mute <= mute;
        r_idx  <= '0;
        r_acc  <= '0;
      end
      if (w_step) begin
        r_acc <= r_acc + AW'(w_prod);
        r_idx <= r_idx + 1'b1;
      end
      if (w_out) begin
        r_mixed  <= w_sat;
        r_sample <= 1'b1;
        // Counter only moves on output samples: reload on a clip, else count down.
        if (w_clip)                 r_peak_cnt <= PW'(PEAK_HOLD);
        else if (r_peak_cnt != '0)  r_peak_cnt <= r_peak_cnt - 1'b1;
      end
    end
  end

  assign mixed  = r_mixed;
  assign sample = r_sample;
  assign peak   = (r_peak_cnt != '0);
  assign busy   = (r_state != StIdle);

endmodule
